// File: rtl/video_pkg.sv
// Shared types for the video stream blocks: the beat payload carried through
// register slices and the frame-mux FSM state encoding.
package video_pkg;

  localparam int VID_DATA_W = 24;

  typedef struct packed {
    logic [VID_DATA_W-1:0] tdata;
    logic                  tlast;
    logic                  tuser;
  } vid_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_PASS
  } vmux_state_t;

endpackage

// File: rtl/video_skid_buf.sv
// Two-entry register slice for vid_beat_t: registered outputs and a registered
// in_ready that depends only on occupancy, so full throughput needs no comb path.
module video_skid_buf
  import video_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  vid_beat_t in_beat,
  output logic      out_valid,
  input  logic      out_ready,
  output vid_beat_t out_beat
);

  logic      out_valid_q, out_valid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      in_ready_q, in_ready_d;
  vid_beat_t out_beat_q, out_beat_d;
  vid_beat_t skid_beat_q, skid_beat_d;
  logic      push;

  always_comb begin
    // NOTE: every _d gets a default first, so no path can leave it unassigned and infer a latch.
    push         = in_valid && in_ready_q;
    out_valid_d  = out_valid_q;
    out_beat_d   = out_beat_q;
    skid_valid_d = skid_valid_q;
    skid_beat_d  = skid_beat_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_beat_d   = skid_beat_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_beat_d = in_beat;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_beat_d  = in_beat;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: payload registers are reset as well, because the output bus must read 0 after reset.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_beat_q   <= '0;
      skid_beat_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_beat_q   <= out_beat_d;
      skid_beat_q  <= skid_beat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_beat  = out_beat_q;

endmodule

// File: rtl/video_frame_mux.sv
// Two-source AXI4-Stream video merger switching only on frame boundaries.
// Define VIDEO_FRAME_MUX_FLUSH_EN to let the non-granted source drain freely.
module video_frame_mux
  import video_pkg::*;
#(
  parameter int DATA_W     = VID_DATA_W,
  parameter int LINES      = 720,
  parameter int LINE_CNT_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [DATA_W-1:0] s0_axis_video_tdata,
  input  logic              s0_axis_video_tvalid,
  output logic              s0_axis_video_tready,
  input  logic              s0_axis_video_tlast,
  input  logic              s0_axis_video_tuser,
  input  logic [DATA_W-1:0] s1_axis_video_tdata,
  input  logic              s1_axis_video_tvalid,
  output logic              s1_axis_video_tready,
  input  logic              s1_axis_video_tlast,
  input  logic              s1_axis_video_tuser,
  output logic [DATA_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  input  logic              m_axis_video_tready,
  output logic              m_axis_video_tlast,
  output logic              m_axis_video_tuser,
  output logic              active_src,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(LINES - 1);

  vmux_state_t           state_q, state_d;
  logic                  active_src_q, active_src_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_err_q, frame_err_d;

  logic      g_valid, g_ready, acc, push, flush_src, flush_rdy;
  logic      skid_in_ready, skid_out_valid;
  vid_beat_t g_beat, skid_out_beat;

`ifdef VIDEO_FRAME_MUX_FLUSH_EN
  logic run_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end
  assign flush_rdy = run_q;
`else
  assign flush_rdy = 1'b0;
`endif

  always_comb begin
    g_valid = active_src_q ? s1_axis_video_tvalid : s0_axis_video_tvalid;
    g_beat  = active_src_q
            ? '{tdata: VID_DATA_W'(s1_axis_video_tdata), tlast: s1_axis_video_tlast, tuser: s1_axis_video_tuser}
            : '{tdata: VID_DATA_W'(s0_axis_video_tdata), tlast: s0_axis_video_tlast, tuser: s0_axis_video_tuser};
    g_ready = (state_q != ST_IDLE) && skid_in_ready;
    acc     = g_valid && g_ready;
    // In IDLE the source about to be granted is sel, so only the other one may be flushed.
    flush_src = (state_q == ST_IDLE) ? !sel : !active_src_q;
    s0_axis_video_tready = (!active_src_q && g_ready) || (flush_rdy && !flush_src);
    s1_axis_video_tready = ( active_src_q && g_ready) || (flush_rdy &&  flush_src);
  end

  always_comb begin
    state_d      = state_q;
    active_src_d = active_src_q;
    line_cnt_d   = line_cnt_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    push         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        active_src_d = sel;
        state_d      = ST_SEEK;
      end
      ST_SEEK: begin
        // Beats before SOF are accepted and dropped.
        if (acc && g_beat.tuser) begin
          push       = 1'b1;
          state_d    = ST_PASS;
          line_cnt_d = '0;
          if (g_beat.tlast) begin
            if (LAST_LINE == '0) begin
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              line_cnt_d = LINE_CNT_W'(1);
            end
          end
        end
      end
      ST_PASS: begin
        if (acc) begin
          push = 1'b1;
          if (g_beat.tlast && line_cnt_q == LAST_LINE) begin
            frame_done_d = 1'b1;
            line_cnt_d   = '0;
            state_d      = ST_IDLE;
          end else if (g_beat.tuser) begin
            frame_err_d = 1'b1;
            line_cnt_d  = g_beat.tlast ? LINE_CNT_W'(1) : '0;
          end else if (g_beat.tlast) begin
            line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      active_src_q <= 1'b0;
      line_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_src_q <= active_src_d;
      line_cnt_q   <= line_cnt_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  video_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (skid_in_ready),
    .in_beat   (g_beat),
    .out_valid (skid_out_valid),
    .out_ready (m_axis_video_tready),
    .out_beat  (skid_out_beat)
  );

  assign m_axis_video_tdata  = DATA_W'(skid_out_beat.tdata);
  assign m_axis_video_tlast  = skid_out_beat.tlast;
  assign m_axis_video_tuser  = skid_out_beat.tuser;
  assign m_axis_video_tvalid = skid_out_valid;
  assign active_src          = active_src_q;
  assign frame_done          = frame_done_q;
  assign frame_err           = frame_err_q;

endmodule

// File: tb/tb_video_frame_mux.sv
// Directed bench for video_frame_mux with LINES=4: drivers push expected beats
// into a queue, a negedge monitor collects the merged output for comparison.
module tb_video_frame_mux;

  localparam int DW    = 24;
  localparam int LINES = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0, m_tdata;
  logic          s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tuser = 1'b0, s0_tready;
  logic          s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tuser = 1'b0, s1_tready;
  logic          m_tvalid, m_tlast, m_tuser;
  logic          m_tready = 1'b0;
  logic          active_src, frame_done, frame_err;

  int total = 0;
  int bad   = 0;
  int sink_mode = 0;  // 0 = always ready, 1 = random, 2 = stalled
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [25:0] exp_q[$];
  logic [25:0] got_q[$];

  video_frame_mux #(.DATA_W(DW), .LINES(LINES), .LINE_CNT_W(12)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .sel                  (sel),
    .s0_axis_video_tdata  (s0_tdata),
    .s0_axis_video_tvalid (s0_tvalid),
    .s0_axis_video_tready (s0_tready),
    .s0_axis_video_tlast  (s0_tlast),
    .s0_axis_video_tuser  (s0_tuser),
    .s1_axis_video_tdata  (s1_tdata),
    .s1_axis_video_tvalid (s1_tvalid),
    .s1_axis_video_tready (s1_tready),
    .s1_axis_video_tlast  (s1_tlast),
    .s1_axis_video_tuser  (s1_tuser),
    .m_axis_video_tdata   (m_tdata),
    .m_axis_video_tvalid  (m_tvalid),
    .m_axis_video_tready  (m_tready),
    .m_axis_video_tlast   (m_tlast),
    .m_axis_video_tuser   (m_tuser),
    .active_src           (active_src),
    .frame_done           (frame_done),
    .frame_err            (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (sink_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) got_q.push_back({m_tuser, m_tlast, m_tdata});
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int src, input int tag, input int l, input int p);
    return {4'(src), 4'(tag), 8'(l), 8'(p)};
  endfunction

  // Called just after a negedge; returns just after the negedge following the handshake.
  task automatic send_beat(input bit src, input logic [23:0] d, input bit last, input bit user,
                           input bit fwd);
    int n = 0;
    bit hs = 1'b0;
    if (src) begin s1_tdata = d; s1_tlast = last; s1_tuser = user; s1_tvalid = 1'b1; end
    else     begin s0_tdata = d; s0_tlast = last; s0_tuser = user; s0_tvalid = 1'b1; end
    while (!hs && n < 200) begin
      #3;
      hs = src ? s1_tready : s0_tready;
      @(negedge clk);
      n++;
    end
    if (src) s1_tvalid = 1'b0; else s0_tvalid = 1'b0;
    if (!hs) check("hs_timeout", 32'd0, 32'd1);
    else if (fwd) exp_q.push_back({user, last, d});
  endtask

  task automatic send_frame(input bit src, input int tag, input int nlines, input int w,
                            input bit fwd);
    for (int l = 0; l < nlines; l++)
      for (int p = 0; p < w; p++)
        send_beat(src, pix(src, tag, l, p), p == w - 1, l == 0 && p == 0, fwd);
  endtask

  task automatic drain_cmp(input string name, input int exp_done, input int exp_err);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
    check({name, "_done"}, done_cnt, exp_done);
    check({name, "_err"}, err_cnt, exp_err);
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  initial begin
    logic exp_flush;
`ifdef VIDEO_FRAME_MUX_FLUSH_EN
    exp_flush = 1'b1;
`else
    exp_flush = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_s0_tready", s0_tready, 0);
    check("rst_s1_tready", s1_tready, 0);
    check("rst_active", active_src, 0);
    check("rst_done", frame_done, 0);
    rst = 1'b0;

    // T1: junk before SOF is dropped, 4x8 frame forwarded.
    send_beat(0, 24'h0000EE, 1'b0, 1'b0, 1'b0);
    send_beat(0, 24'h0000EF, 1'b1, 1'b0, 1'b0);
    send_frame(0, 1, 4, 8, 1'b1);
    drain_cmp("t1", 1, 0);
    check("t1_active", active_src, 0);

    // T2: sel flips mid-frame; s0 frame completes, then s1 is granted.
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 4; p++) begin
        if (l == 2 && p == 0) sel = 1'b1;
        if (l == 2 && p == 2) check("t2_hold_s0", active_src, 0);
        send_beat(0, pix(0, 2, l, p), p == 3, l == 0 && p == 0, 1'b1);
      end
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 4; p++) begin
        send_beat(1, pix(1, 2, l, p), p == 3, l == 0 && p == 0, 1'b1);
        if (l == 0 && p == 0) begin
          check("t2_active_s1", active_src, 1);
          sel = 1'b0;
        end
      end
    drain_cmp("t2", 2, 0);

    // T3: random sink back-pressure.
    sink_mode = 1;
    send_frame(0, 3, 4, 4, 1'b1);
    sink_mode = 0;
    drain_cmp("t3", 1, 0);

    // T4: SOF after two lines restarts the line count.
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 4; p++)
        send_beat(0, pix(0, 4, l, p), p == 3, l == 0 && p == 0, 1'b1);
    send_frame(0, 5, 4, 4, 1'b1);
    drain_cmp("t4", 1, 1);

    // T5: reset with beats stuck in the slice.
    sink_mode = 2;
    @(negedge clk);
    send_beat(0, pix(0, 6, 0, 0), 1'b0, 1'b1, 1'b0);
    send_beat(0, pix(0, 6, 0, 1), 1'b0, 1'b0, 1'b0);
    check("t5_pre_tvalid", m_tvalid, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_tvalid", m_tvalid, 0);
    check("t5_rst_tdata", m_tdata, 0);
    check("t5_rst_tuser", m_tuser, 0);
    check("t5_rst_s0_tready", s0_tready, 0);
    @(negedge clk);
    rst = 1'b0;
    sink_mode = 0;
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
    send_beat(0, pix(0, 6, 0, 2), 1'b0, 1'b0, 1'b0);
    send_beat(0, pix(0, 6, 0, 3), 1'b1, 1'b0, 1'b0);
    send_frame(0, 7, 4, 4, 1'b1);
    drain_cmp("t5", 1, 0);

    // T6: non-granted s1 streams SOF-flagged junk continuously.
    s1_tdata  = 24'hDEAD01;
    s1_tuser  = 1'b1;
    s1_tlast  = 1'b1;
    s1_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("t6_s1_tready", s1_tready, exp_flush);
    @(negedge clk);
    send_frame(0, 8, 4, 4, 1'b1);
    #3;
    check("t6_s1_tready_end", s1_tready, exp_flush);
    @(negedge clk);
    s1_tvalid = 1'b0;
    drain_cmp("t6", 1, 0);
    check("t6_active", active_src, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
